ccx_ic_rr_arbiter: RTL and testbench

- Shares one downstream memory port (ROM, RAM or EXT) between NREQ core-side requesters, normally the data and instruction memory routers.
- Round-robin arbitration over the request channel.
- Holds the grant choice while a request is stalled.
- Tracks outstanding transactions in an ID FIFO so in-order responses return to the requester that issued them.
- Sits between the per-core routers and each memory target in the core complex interconnect.

---
 rtl/ccx_ic_rr_arbiter_if.sv | 43 ++++
 rtl/ccx_ic_rr_arbiter.sv | 104 ++++++++++
 tb/tb_ccx_ic_rr_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ccx_ic_rr_arbiter_if.sv
// ccx_ic_rr_arbiter_if: requester-side and target-side buses of the shared memory port arbiter.
// slave is the arbiter's view, master is the view of the surrounding routers/target.
interface ccx_ic_rr_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 39,
    parameter int DW   = 64,
    parameter int SW   = DW / 8
);
    logic [NREQ-1:0]    req_req;
    logic [NREQ-1:0]    req_gnt;
    logic [NREQ-1:0]    req_wen;
    logic [NREQ*SW-1:0] req_strb;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_recv;
    logic [NREQ-1:0]    req_ack;
    logic               req_error;
    logic [DW-1:0]      req_rdata;
    logic               mem_req;
    logic               mem_gnt;
    logic               mem_wen;
    logic [SW-1:0]      mem_strb;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               mem_recv;
    logic               mem_ack;
    logic               mem_error;
    logic [DW-1:0]      mem_rdata;

    modport slave (
        input  req_req, req_wen, req_strb, req_addr, req_wdata, req_ack,
        input  mem_gnt, mem_recv, mem_error, mem_rdata,
        output req_gnt, req_recv, req_error, req_rdata,
        output mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack
    );

    modport master (
        output req_req, req_wen, req_strb, req_addr, req_wdata, req_ack,
        output mem_gnt, mem_recv, mem_error, mem_rdata,
        input  req_gnt, req_recv, req_error, req_rdata,
        input  mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack
    );
endinterface

// File: rtl/ccx_ic_rr_arbiter.sv
// ccx_ic_rr_arbiter: round-robin share of one memory target among NREQ requesters with in-order response routing.
// Define CCX_IC_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module ccx_ic_rr_arbiter #(
    parameter int NREQ        = 2,
    parameter int AW          = 39,
    parameter int DW          = 64,
    parameter int SW          = DW / 8,
    parameter int OUTSTANDING = 2
) (
    input logic g_clk,
    input logic g_reset,
    ccx_ic_rr_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  lock_id_q, lock_id_d;
    logic [IW-1:0]  fifo_q [OUTSTANDING];
    logic [IW-1:0]  fifo_d [OUTSTANDING];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  base, scan_sel, sel, head;
    logic           full, empty, mreq, xfer, pop;

`ifdef CCX_IC_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    assign base = rr_ptr_q;
    assign rr_ptr_d = xfer ? ((sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1) : rr_ptr_q;
`endif

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reverse scan so the first asserted index at or after base wins.
    always_comb begin
        scan_sel = base;
        for (int k = NREQ - 1; k >= 0; k--)
            if (bus.req_req[(int'(base) + k) % NREQ]) scan_sel = IW'((int'(base) + k) % NREQ);
    end

    assign sel   = (state_q == HOLD) ? lock_id_q : scan_sel;
    assign full  = cnt_q == CW'(OUTSTANDING);
    assign empty = cnt_q == '0;
    assign head  = fifo_q[rd_q];
    assign mreq  = !g_reset && bus.req_req[sel] && !full;
    assign xfer  = mreq && bus.mem_gnt;
    assign pop   = !g_reset && !empty && bus.mem_recv && bus.req_ack[head];

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
            fifo_q    <= '{default: '0};
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
`ifndef CCX_IC_ARB_FIXED_PRIO_EN
            rr_ptr_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            fifo_q    <= fifo_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
`ifndef CCX_IC_ARB_FIXED_PRIO_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

    // A dropped request in HOLD abandons the lock without a transfer.
    always_comb begin
        state_d   = (state_q == IDLE) ? ((mreq && !bus.mem_gnt) ? HOLD : IDLE)
                                      : ((xfer || !bus.req_req[lock_id_q]) ? IDLE : HOLD);
        lock_id_d = sel;
        fifo_d    = fifo_q;
        if (xfer) fifo_d[wr_q] = sel;
        wr_d      = xfer ? nxt(wr_q) : wr_q;
        rd_d      = pop ? nxt(rd_q) : rd_q;
        cnt_d     = cnt_q + CW'(xfer) - CW'(pop);
    end

    always_comb begin
        bus.mem_req   = mreq;
        bus.mem_wen   = bus.req_wen[sel];
        bus.mem_strb  = bus.req_strb[int'(sel) * SW +: SW];
        bus.mem_addr  = bus.req_addr[int'(sel) * AW +: AW];
        bus.mem_wdata = bus.req_wdata[int'(sel) * DW +: DW];
        bus.req_gnt   = xfer ? NREQ'(1) << sel : '0;
        bus.req_recv  = (!g_reset && !empty && bus.mem_recv) ? NREQ'(1) << head : '0;
        bus.mem_ack   = !g_reset && !empty && bus.req_ack[head];
        bus.req_rdata = bus.mem_rdata;
        bus.req_error = bus.mem_error;
    end
endmodule

// File: tb/tb_ccx_ic_rr_arbiter.sv
// tb_ccx_ic_rr_arbiter: scoreboard bench with a queue-based reference model of the arbiter.
module tb_ccx_ic_rr_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 39;
    localparam int DW   = 64;
    localparam int SW   = DW / 8;
    localparam int OUT  = 2;

    typedef struct {
        int cyc; int id; logic gnt; logic wen;
        logic [SW-1:0] strb; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    } req_ev_t;
    typedef struct {
        int cyc; int id; logic recv; logic ack; logic [DW-1:0] rdata; logic err;
    } rsp_ev_t;

    logic g_clk = 1'b0;
    logic g_reset = 1'b1;
    always #5 g_clk = ~g_clk;

    ccx_ic_rr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW)) bus();
    ccx_ic_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW), .OUTSTANDING(OUT)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .bus(bus)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;
    req_ev_t req_q[$];
    rsp_ev_t rsp_q[$];
    int mq[$];
    int rr = 0, lock = -1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [NREQ-1:0] rq, input logic gnt,
                        input logic recv, input logic [NREQ-1:0] ack);
        int sel, base;
        bit full, mreq;
        @(negedge g_clk);
        cyc++;
        g_reset = rst;
        bus.req_req = rq;
        bus.mem_gnt = gnt;
        bus.mem_recv = recv;
        bus.req_ack = ack;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_wen[i] = 1'($urandom);
            bus.req_strb[i*SW +: SW] = SW'($urandom);
            bus.req_addr[i*AW +: AW] = AW'({$urandom, $urandom});
            bus.req_wdata[i*DW +: DW] = {$urandom, $urandom};
        end
        bus.mem_rdata = {$urandom, $urandom};
        bus.mem_error = 1'($urandom);
        if (rst) begin
            mq.delete();
            rr = 0;
            lock = -1;
        end else begin
            full = mq.size() == OUT;
`ifdef CCX_IC_ARB_FIXED_PRIO_EN
            base = 0;
`else
            base = rr;
`endif
            sel = lock;
            for (int k = 0; k < NREQ; k++)
                if (sel < 0 && rq[(base + k) % NREQ]) sel = (base + k) % NREQ;
            mreq = sel >= 0 && rq[sel] && !full;
            if (mq.size() > 0 && (recv || ack[mq[0]]))
                rsp_q.push_back('{cyc, mq[0], recv, ack[mq[0]], bus.mem_rdata, bus.mem_error});
            if (mreq)
                req_q.push_back('{cyc, sel, gnt, bus.req_wen[sel], bus.req_strb[sel*SW +: SW],
                                  bus.req_addr[sel*AW +: AW], bus.req_wdata[sel*DW +: DW]});
            if (mq.size() > 0 && recv && ack[mq[0]]) void'(mq.pop_front());
            if (mreq && gnt) begin
                mq.push_back(sel);
                rr = (sel + 1) % NREQ;
                lock = -1;
            end else begin
                lock = mreq ? sel : -1;
            end
        end
    endtask

    initial begin
        req_ev_t e;
        rsp_ev_t r;
        forever begin
            @(negedge g_clk);
            #2;
            if (g_reset) begin
                chk("rst_mem_req", bus.mem_req, 0);
                chk("rst_req_gnt", bus.req_gnt, 0);
                chk("rst_req_recv", bus.req_recv, 0);
                chk("rst_mem_ack", bus.mem_ack, 0);
            end else begin
                while (req_q.size() > 0 && req_q[0].cyc < cyc) begin
                    n_chk++; n_fail++;
                    $display("FAIL req_missing cycle %0d: got no mem_req expected requester %0d", req_q[0].cyc, req_q[0].id);
                    void'(req_q.pop_front());
                end
                while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                    n_chk++; n_fail++;
                    $display("FAIL rsp_missing cycle %0d: got no response expected requester %0d", rsp_q[0].cyc, rsp_q[0].id);
                    void'(rsp_q.pop_front());
                end
                if (bus.mem_req) begin
                    if (req_q.size() == 0 || req_q[0].cyc != cyc) begin
                        n_chk++; n_fail++;
                        $display("FAIL req_unexpected cycle %0d: got mem_req=1 expected 0", cyc);
                    end else begin
                        e = req_q.pop_front();
                        chk("req_gnt", bus.req_gnt, e.gnt ? (1 << e.id) : 0);
                        chk("mem_addr", bus.mem_addr, e.addr);
                        chk("mem_wen", bus.mem_wen, e.wen);
                        chk("mem_strb", bus.mem_strb, e.strb);
                        chk("mem_wdata", bus.mem_wdata, e.wdata);
                    end
                end else begin
                    chk("gnt_idle", bus.req_gnt, 0);
                end
                if (bus.req_recv != 0 || bus.mem_ack) begin
                    if (rsp_q.size() == 0 || rsp_q[0].cyc != cyc) begin
                        n_chk++; n_fail++;
                        $display("FAIL rsp_unexpected cycle %0d: got recv=%0h ack=%0b expected none", cyc, bus.req_recv, bus.mem_ack);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("req_recv", bus.req_recv, r.recv ? (1 << r.id) : 0);
                        chk("mem_ack", bus.mem_ack, r.ack);
                        if (r.recv) begin
                            chk("req_rdata", bus.req_rdata, r.rdata);
                            chk("req_error", bus.req_error, r.err);
                        end
                    end
                end
            end
        end
    end

    initial begin
        bus.req_req = '0; bus.mem_gnt = 0; bus.mem_recv = 0; bus.req_ack = '0;
        bus.req_wen = '0; bus.req_strb = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.mem_rdata = '0; bus.mem_error = 0;
        repeat (2) step(1, 2'b00, 0, 0, 2'b00);
        repeat (8) step(0, 2'b11, 1, 1, 2'b11);
        repeat (2) step(0, 2'b00, 0, 1, 2'b11);
        repeat (2) step(0, 2'b10, 0, 0, 2'b00);
        step(0, 2'b11, 0, 0, 2'b00);
        step(0, 2'b11, 1, 0, 2'b00);
        step(0, 2'b11, 1, 0, 2'b00);
        repeat (2) step(0, 2'b11, 1, 0, 2'b00);
        step(0, 2'b11, 1, 1, 2'b11);
        step(0, 2'b11, 1, 0, 2'b00);
        repeat (4) step(0, 2'b00, 0, 1, 2'b00);
        repeat (3) step(0, 2'b00, 0, 1, 2'b11);
        step(0, 2'b01, 1, 0, 2'b00);
        step(0, 2'b10, 0, 0, 2'b00);
        step(1, 2'b11, 0, 0, 2'b00);
        step(0, 2'b11, 1, 0, 2'b00);
        for (int n = 0; n < 3000; n++)
            step(($urandom_range(0, 249) == 0), NREQ'($urandom), ($urandom_range(0, 3) != 0),
                 1'($urandom), NREQ'($urandom));
        step(0, 2'b00, 0, 0, 2'b00);
        #5;
        foreach (req_q[i]) begin
            n_chk++; n_fail++;
            $display("FAIL req_leftover cycle %0d: got nothing expected requester %0d", req_q[i].cyc, req_q[i].id);
        end
        foreach (rsp_q[i]) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_leftover cycle %0d: got nothing expected requester %0d", rsp_q[i].cyc, rsp_q[i].id);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
